// File: rtl/rv_encode_pkg.sv
// Shared RV32I encoding constants and types for the instruction encoder and control unit.
package rv_encode_pkg;

    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [2:0] F3_ADDI   = 3'b000;
    localparam logic [2:0] F3_BNE    = 3'b001;

    localparam int unsigned IMM_W = 13;
    localparam int unsigned REG_W = 5;
    localparam int unsigned WORD_W = 32;

    typedef enum logic [1:0] {
        KIND_ADDI = 2'b00,
        KIND_BNE  = 2'b01,
        KIND_END  = 2'b10,
        KIND_RSVD = 2'b11
    } cmd_kind_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WRITE,
        ST_DONE,
        ST_ERROR
    } state_e;

    // Symbolic command as accepted over the handshake
    typedef struct packed {
        cmd_kind_e         kind;
        logic [REG_W-1:0]  rd;
        logic [REG_W-1:0]  rs1;
        logic [REG_W-1:0]  rs2;
        logic [IMM_W-1:0]  imm;
    } cmd_t;

endpackage

// File: rtl/instr_pack.sv
// Combinational packer: symbolic command to RV32I word, flagging out-of-range or reserved commands.
module instr_pack
    import rv_encode_pkg::*;
(
    input  cmd_t              cmd_i,
    output logic [WORD_W-1:0] word_o,
    output logic              range_fault_o
);

    always_comb begin
        word_o        = '0;
        range_fault_o = 1'b0;
        case (cmd_i.kind)
            KIND_ADDI: begin
                word_o = {cmd_i.imm[11:0], cmd_i.rs1, F3_ADDI, cmd_i.rd, OP_IMM};
                // 12-bit signed range holds only when the top two imm bits agree
                range_fault_o = cmd_i.imm[12] ^ cmd_i.imm[11];
            end
            KIND_BNE: begin
                word_o = {cmd_i.imm[12], cmd_i.imm[10:5], cmd_i.rs2, cmd_i.rs1, F3_BNE,
                          cmd_i.imm[4:1], cmd_i.imm[11], OP_BRANCH};
                // 13-bit field already bounds the range; only odd offsets are illegal
                range_fault_o = cmd_i.imm[0];
            end
            KIND_END: begin
                range_fault_o = 1'b0;
            end
            default: begin
                range_fault_o = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/instr_encoder.sv
// Program loader: accepts symbolic commands, encodes them and writes consecutive
// instruction-memory words starting at BASE_ADDR.
module instr_encoder
    import rv_encode_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned BASE_ADDR  = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [1:0]            cmd_kind,
    input  logic [4:0]            cmd_rd,
    input  logic [4:0]            cmd_rs1,
    input  logic [4:0]            cmd_rs2,
    input  logic [12:0]           cmd_imm,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic [ADDR_WIDTH-1:0] count,
    output logic                  done,
    output logic                  err
);

    localparam int unsigned         CAPACITY = 1 << (ADDR_WIDTH - 2);
    localparam logic [ADDR_WIDTH-1:0] CAP_CNT  = ADDR_WIDTH'(CAPACITY);
    localparam logic [ADDR_WIDTH-1:0] BASE     = ADDR_WIDTH'(BASE_ADDR);

    state_e                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   ptr_q, ptr_d;
    logic [ADDR_WIDTH-1:0]   count_q, count_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic                    ready_q, ready_d;
    logic                    we_q, we_d;
    logic                    done_q, done_d;
    logic                    err_q, err_d;

    cmd_t                    cmd;
    logic [WORD_W-1:0]       packed_word;
    logic                    range_fault;
    logic                    is_write;
    logic                    full;

    always_comb begin
        cmd.kind = cmd_kind_e'(cmd_kind);
        cmd.rd   = cmd_rd;
        cmd.rs1  = cmd_rs1;
        cmd.rs2  = cmd_rs2;
        cmd.imm  = cmd_imm;
    end

    instr_pack u_pack (
        .cmd_i         (cmd),
        .word_o        (packed_word),
        .range_fault_o (range_fault)
    );

    assign is_write = (cmd.kind == KIND_ADDI) || (cmd.kind == KIND_BNE);
    assign full     = (count_q == CAP_CNT);

    // Next-state, pointer/count update and registered-output staging
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        count_d = count_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    if (range_fault || (is_write && full)) begin
                        state_d = ST_ERROR;
                    end else if (cmd.kind == KIND_END) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_WRITE;
                        addr_d  = ptr_q;
                        wdata_d = DATA_WIDTH'(packed_word);
                    end
                end
            end
            ST_WRITE: begin
                ptr_d   = ptr_q + ADDR_WIDTH'(4);
                if (count_q != CAP_CNT) begin
                    count_d = count_q + ADDR_WIDTH'(1);
                end
                state_d = ST_IDLE;
            end
            ST_DONE:  state_d = ST_DONE;
            ST_ERROR: state_d = ST_ERROR;
            default:  state_d = ST_IDLE;
        endcase
        ready_d = (state_d == ST_IDLE);
        we_d    = (state_d == ST_WRITE);
        done_d  = (state_d == ST_DONE);
        err_d   = (state_d == ST_ERROR);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            ptr_q   <= BASE;
            count_q <= '0;
            addr_q  <= BASE;
            wdata_q <= '0;
            ready_q <= 1'b1;
            we_q    <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            count_q <= count_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            ready_q <= ready_d;
            we_q    <= we_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign cmd_ready = ready_q;
    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign count     = count_q;
    assign done      = done_q;
    assign err       = err_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Scoreboard bench for instr_encoder: directed commands push expected memory writes,
// per-DUT monitors pop and compare on every write strobe.
module tb_instr_encoder;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_a, rst_b, valid_a, valid_b;
    logic [1:0]  kind;
    logic [4:0]  rd, rs1, rs2;
    logic [12:0] imm;

    logic        ready_a, we_a, done_a, err_a;
    logic [7:0]  addr_a, count_a;
    logic [31:0] wdata_a;

    logic        ready_b, we_b, done_b, err_b;
    logic [3:0]  addr_b, count_b;
    logic [31:0] wdata_b;

    instr_encoder #(.DATA_WIDTH(32), .ADDR_WIDTH(8), .BASE_ADDR(0)) dut_a (
        .clk(clk), .rst(rst_a), .cmd_valid(valid_a), .cmd_ready(ready_a),
        .cmd_kind(kind), .cmd_rd(rd), .cmd_rs1(rs1), .cmd_rs2(rs2), .cmd_imm(imm),
        .mem_we(we_a), .mem_addr(addr_a), .mem_wdata(wdata_a),
        .count(count_a), .done(done_a), .err(err_a)
    );

    instr_encoder #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .BASE_ADDR(0)) dut_b (
        .clk(clk), .rst(rst_b), .cmd_valid(valid_b), .cmd_ready(ready_b),
        .cmd_kind(kind), .cmd_rd(rd), .cmd_rs1(rs1), .cmd_rs2(rs2), .cmd_imm(imm),
        .mem_we(we_b), .mem_addr(addr_b), .mem_wdata(wdata_b),
        .count(count_b), .done(done_b), .err(err_b)
    );

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic mon_a();
        exp_t e;
        forever begin
            @(negedge clk);
            if (we_a) begin
                if (q_a.size() == 0) begin
                    n_vec++; n_err++;
                    $display("FAIL unexpected_write_a: addr 0x%02h data 0x%08h, expected no write", addr_a, wdata_a);
                end else begin
                    e = q_a.pop_front();
                    chk("wr_addr_a", 32'(addr_a), e.addr);
                    chk("wr_data_a", wdata_a, e.data);
                end
            end
        end
    endtask

    task automatic mon_b();
        exp_t e;
        forever begin
            @(negedge clk);
            if (we_b) begin
                if (q_b.size() == 0) begin
                    n_vec++; n_err++;
                    $display("FAIL unexpected_write_b: addr 0x%01h data 0x%08h, expected no write", addr_b, wdata_b);
                end else begin
                    e = q_b.pop_front();
                    chk("wr_addr_b", 32'(addr_b), e.addr);
                    chk("wr_data_b", wdata_b, e.data);
                end
            end
        end
    endtask

    task automatic push_a(input logic [31:0] a, input logic [31:0] d);
        exp_t e;
        e.addr = a; e.data = d;
        q_a.push_back(e);
    endtask

    task automatic push_b(input logic [31:0] a, input logic [31:0] d);
        exp_t e;
        e.addr = a; e.data = d;
        q_b.push_back(e);
    endtask

    // Drive one command once cmd_ready is seen; returns just after the accepting edge
    task automatic send(input bit sel, input logic [1:0] k, input logic [4:0] d_rd,
                        input logic [4:0] s1, input logic [4:0] s2, input logic [12:0] im);
        int t = 0;
        @(negedge clk);
        while (!(sel ? ready_b : ready_a) && t < 20) begin
            @(negedge clk);
            t++;
        end
        if (t >= 20) begin
            n_vec++; n_err++;
            $display("FAIL ready_timeout: cmd_ready still 0 after 20 cycles, expected 1");
            return;
        end
        kind = k; rd = d_rd; rs1 = s1; rs2 = s2; imm = im;
        if (sel) valid_b = 1'b1;
        else     valid_a = 1'b1;
        @(posedge clk);
        #1;
        valid_a = 1'b0;
        valid_b = 1'b0;
    endtask

    task automatic reset_a();
        @(negedge clk);
        rst_a = 1'b1;
        @(negedge clk);
        rst_a = 1'b0;
    endtask

    logic [1:0]  f_kind [5] = '{2'b00, 2'b00, 2'b01, 2'b01, 2'b11};
    logic [12:0] f_imm  [5] = '{13'h0800, 13'h17FF, 13'h0003, 13'h0FFF, 13'h0000};

    initial begin
        rst_a = 1'b1; rst_b = 1'b1; valid_a = 1'b0; valid_b = 1'b0;
        kind = '0; rd = '0; rs1 = '0; rs2 = '0; imm = '0;
        fork
            mon_a();
            mon_b();
        join_none
        repeat (2) @(posedge clk);
        #1;
        rst_a = 1'b0; rst_b = 1'b0;

        @(negedge clk);
        chk("rst_ready", 32'(ready_a), 32'd1);
        chk("rst_we",    32'(we_a),    32'd0);
        chk("rst_addr",  32'(addr_a),  32'd0);
        chk("rst_wdata", wdata_a,      32'd0);
        chk("rst_count", 32'(count_a), 32'd0);
        chk("rst_done",  32'(done_a),  32'd0);
        chk("rst_err",   32'(err_a),   32'd0);

        push_a(32'h00, 32'h00500093);
        send(1'b0, 2'b00, 5'd1, 5'd0, 5'd0, 13'd5);
        @(negedge clk);
        chk("ready_in_write_addi", 32'(ready_a), 32'd0);
        @(negedge clk);
        chk("count_after_addi", 32'(count_a), 32'd1);
        chk("ready_after_addi", 32'(ready_a), 32'd1);

        push_a(32'h04, 32'hFE209CE3);
        send(1'b0, 2'b01, 5'd0, 5'd1, 5'd2, 13'h1FF8);
        @(negedge clk);
        chk("ready_in_write_bne", 32'(ready_a), 32'd0);
        @(negedge clk);
        chk("count_after_bne", 32'(count_a), 32'd2);
        chk("addr_held",       32'(addr_a),  32'h04);
        chk("wdata_held",      wdata_a,      32'hFE209CE3);

        send(1'b0, 2'b10, 5'd0, 5'd0, 5'd0, 13'd0);
        @(negedge clk);
        chk("end_done",  32'(done_a),  32'd1);
        chk("end_ready", 32'(ready_a), 32'd0);
        kind = 2'b00; rd = 5'd7; imm = 13'd1; valid_a = 1'b1;
        repeat (3) @(negedge clk);
        valid_a = 1'b0;
        chk("ignored_count", 32'(count_a), 32'd2);
        chk("done_sticky",   32'(done_a),  32'd1);
        chk("no_err_on_end", 32'(err_a),   32'd0);
        reset_a();
        chk("rst2_count", 32'(count_a), 32'd0);
        chk("rst2_done",  32'(done_a),  32'd0);
        chk("rst2_addr",  32'(addr_a),  32'd0);
        chk("rst2_ready", 32'(ready_a), 32'd1);

        // Immediate boundaries that must still encode
        push_a(32'h00, 32'h800F8F93);
        send(1'b0, 2'b00, 5'd31, 5'd31, 5'd0, 13'h1800);
        push_a(32'h04, 32'h7FF18113);
        send(1'b0, 2'b00, 5'd2, 5'd3, 5'd0, 13'h07FF);
        push_a(32'h08, 32'h7E521FE3);
        send(1'b0, 2'b01, 5'd0, 5'd4, 5'd5, 13'h0FFE);
        push_a(32'h0C, 32'h80001063);
        send(1'b0, 2'b01, 5'd0, 5'd0, 5'd0, 13'h1000);
        repeat (2) @(negedge clk);
        chk("count_boundary", 32'(count_a), 32'd4);
        chk("err_boundary",   32'(err_a),   32'd0);

        for (int i = 0; i < 5; i++) begin
            reset_a();
            send(1'b0, f_kind[i], 5'd1, 5'd1, 5'd2, f_imm[i]);
            @(negedge clk);
            chk($sformatf("fault%0d_err", i),   32'(err_a),   32'd1);
            chk($sformatf("fault%0d_ready", i), 32'(ready_a), 32'd0);
            repeat (2) @(negedge clk);
            chk($sformatf("fault%0d_sticky", i), 32'(err_a),   32'd1);
            chk($sformatf("fault%0d_count", i),  32'(count_a), 32'd0);
        end

        reset_a();
        push_a(32'h00, 32'hFFF20193);
        send(1'b0, 2'b00, 5'd3, 5'd4, 5'd0, 13'h1FFF);
        rst_a = 1'b1;
        repeat (2) @(negedge clk);
        chk("midwrite_we",    32'(we_a),    32'd0);
        chk("midwrite_count", 32'(count_a), 32'd0);
        chk("midwrite_ready", 32'(ready_a), 32'd1);
        rst_a = 1'b0;

        for (int i = 0; i < 4; i++) begin
            push_b(32'(4 * i), (32'(i) << 20) | (32'(i + 1) << 7) | 32'h13);
            send(1'b1, 2'b00, 5'(i + 1), 5'd0, 5'd0, 13'(i));
        end
        repeat (2) @(negedge clk);
        chk("b_count_full", 32'(count_b), 32'd4);
        send(1'b1, 2'b00, 5'd5, 5'd0, 5'd0, 13'd4);
        @(negedge clk);
        chk("b_full_err",   32'(err_b),   32'd1);
        chk("b_full_ready", 32'(ready_b), 32'd0);
        chk("b_full_count", 32'(count_b), 32'd4);

        repeat (3) @(negedge clk);
        chk("q_a_drained", 32'(q_a.size()), 32'd0);
        chk("q_b_drained", 32'(q_b.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: bench did not complete, expected completion");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/instr_encoder.md
# instr_encoder

Sequential RV32I instruction encoder and program loader, the write-side counterpart of the control unit's decode. It accepts symbolic commands (ADDI, BNE, END) over a valid/ready handshake and packs each into a 32-bit machine word. It writes the words to consecutive instruction-memory addresses starting at a base address. It sits between a testbench or boot source and the instruction memory, so programs are produced in the exact encoding that the control unit and immediate generator consume.

## Interface
- DATA_WIDTH, 32, instruction word width.
- ADDR_WIDTH, 8, instruction-memory byte-address width; capacity 2^(ADDR_WIDTH-2) words.
- BASE_ADDR, 0, byte address of first written word; must be word-aligned.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  encoder can accept a command.
- cmd_kind  in  2  00 ADDI, 01 BNE, 10 END, 11 reserved.
- cmd_rd  in  5  destination register (ADDI).
- cmd_rs1  in  5  source 1.
- cmd_rs2  in  5  source 2 (BNE).
- cmd_imm  in  13  signed immediate; ADDI uses value, BNE byte offset.
- mem_we  out  1  instruction-memory write strobe.
- mem_addr  out  ADDR_WIDTH  byte address of write.
- mem_wdata  out  DATA_WIDTH  encoded instruction.
- count  out  ADDR_WIDTH  words written since reset.
- done  out  1  END accepted; sticky.
- err  out  1  fault detected; sticky.

## Operation
- FSM states: IDLE, WRITE, DONE, ERROR.
- IDLE: cmd_ready=1. On cmd_valid&cmd_ready, command is validated and encoded into a holding register.
  - Valid ADDI/BNE: go to WRITE.
  - END: go to DONE; no memory write.
  - Fault: go to ERROR; no memory write.
- WRITE: mem_we=1 for exactly one cycle with mem_addr=ptr, mem_wdata=held word. Then ptr+=4, count+=1, return to IDLE. cmd_ready=0.
- DONE: done=1 and cmd_ready=0 until rst.
- ERROR: err=1 and cmd_ready=0 until rst.
- Faults are evaluated at acceptance:
  - kind=11.
  - ADDI imm outside [-2048, 2047].
  - BNE imm outside [-4096, 4094] or imm[0]=1.
  - Memory full, i.e. count == 2^(ADDR_WIDTH-2).
- ADDI encoding: imm[11:0] | rs1 | 000 | rd | 0010011.
- BNE encoding: imm[12] | imm[10:5] | rs2 | rs1 | 001 | imm[4:1] | imm[11] | 1100011.
- Arithmetic:
  - ptr wraps modulo 2^ADDR_WIDTH but never wraps in service, because the full check fires first.
  - count saturates at capacity.
  - Register fields pass through unchecked (x0 is legal anywhere).

## Timing
- Reset values: cmd_ready=1 (state IDLE), mem_we=0, mem_addr=BASE_ADDR, mem_wdata=0, count=0, done=0, err=0.
- Latency: accept at edge N puts mem_we=1 during cycle N+1. The next accept is possible at edge N+2, giving a throughput of 1 word per 2 cycles.
- Handshake: command fields are sampled only on the accepting edge. cmd_valid while cmd_ready=0 is ignored, with no state change. The source must hold fields stable until accepted.
- mem_addr and mem_wdata are registered and are held stable outside WRITE. mem_wdata keeps the last word.
- rst takes priority over every state, including mid-WRITE: the write strobe drops in the same edge and ptr/count return to reset values.
- Fault and END acceptance take effect on the accepting edge: err or done is 1 in the following cycle.

## Structure
- Package rv_encode_pkg holds:
  - opcode constants OP_IMM=7'b0010011 and OP_BRANCH=7'b1100011.
  - funct3 constants F3_ADDI=3'b000 and F3_BNE=3'b001.
  - cmd_kind enum.
  - FSM state enum.
- The control unit adopts the same opcode/funct3 constants.
- One combinational sub-module, instr_pack, takes kind/rd/rs1/rs2/imm and returns the word plus a range_fault flag. instr_encoder owns the FSM, ptr, count and memory port.

## Test plan
- ADDI rd=1, rs1=0, imm=5 after reset → one cycle later mem_we=1, mem_addr=0x00, mem_wdata=0x00500093; count=1.
- BNE rs1=1, rs2=2, imm=-8 → mem_wdata=0xFE209CE3 at mem_addr=0x04; count=2; cmd_ready low exactly during WRITE.
- ADDI imm=2048, BNE imm=3, and kind=11, each after rst → err=1 the next cycle, mem_we never asserted, cmd_ready stays 0.
- ADDR_WIDTH=4: four valid ADDIs write to 0x0, 0x4, 0x8, 0xC; fifth ADDI → err=1, no write, count=4.
- END after two words → done=1, no write; further cmd_valid ignored; rst → count=0, done=0, mem_addr=BASE_ADDR.
- rst asserted during WRITE cycle → mem_we=0 the next cycle, count unchanged from reset value 0, cmd_ready=1.
